// File: rtl/interrupt_timer_unit.sv
// Machine timer (mtime/mtimecmp) with MMIO access, external interrupt
// synchronizer and a single-request interrupt FSM feeding commit.
module interrupt_timer_unit #(
   parameter int unsigned PRESCALE = 1
) (
   input  logic        clk,
   input  logic        rstN,
   input  logic        mmioReq,
   input  logic        mmioWe,
   input  logic [3:0]  mmioAddr,
   input  logic [31:0] mmioWData,
   output logic [31:0] mmioRData,
   output logic        mmioRValid,
   input  logic        externalIntLine,
   input  logic        csrMIE,
   input  logic        csrMTIE,
   input  logic        csrMEIE,
   output logic        mtip,
   output logic        meip,
   output logic        intReq,
   output logic [4:0]  intCode,
   input  logic        intAck,
   input  logic        mretDone
);

   localparam int unsigned   PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
   localparam logic [4:0]    CODE_TMR   = 5'd7;
   localparam logic [4:0]    CODE_EXT   = 5'd11;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_IN_HANDLER
   } state_e;

   logic [PW-1:0] presc_q, presc_d;
   logic [63:0]   mtime_q, mtime_d;
   logic [63:0]   mtimecmp_q, mtimecmp_d;
   logic          mtip_q, mtip_d;
   logic          meip_sync_q, meip_sync_d;
   logic          meip_q, meip_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          rvalid_q, rvalid_d;
   state_e        state_q, state_d;
   logic [4:0]    int_code_q, int_code_d;

   logic presc_tick;
   logic wr_en;
   logic rd_en;
   logic ext_hit;
   logic tmr_hit;
   logic latched_hit;

   // Prescaler and timer registers; an MMIO write to an mtime half replaces
   // that half outright (the other half keeps its old value, no increment).
   always_comb begin
      presc_tick = (presc_q == PRESC_LAST);
      presc_d    = presc_tick ? '0 : presc_q + 1'b1;
      wr_en      = mmioReq & mmioWe;
      mtime_d    = presc_tick ? mtime_q + 64'd1 : mtime_q;
      mtimecmp_d = mtimecmp_q;
      if (wr_en) begin
         case (mmioAddr)
            4'd0:    mtime_d    = {mtime_q[63:32], mmioWData};
            4'd1:    mtime_d    = {mmioWData, mtime_q[31:0]};
            4'd2:    mtimecmp_d = {mtimecmp_q[63:32], mmioWData};
            4'd3:    mtimecmp_d = {mmioWData, mtimecmp_q[31:0]};
            default: ;
         endcase
      end
   end

   // MMIO read: sample current registers, return one cycle later.
   always_comb begin
      rd_en    = mmioReq & ~mmioWe;
      rvalid_d = rd_en;
      rdata_d  = '0;
      if (rd_en) begin
         case (mmioAddr)
            4'd0:    rdata_d = mtime_q[31:0];
            4'd1:    rdata_d = mtime_q[63:32];
            4'd2:    rdata_d = mtimecmp_q[31:0];
            4'd3:    rdata_d = mtimecmp_q[63:32];
            default: rdata_d = '0;
         endcase
      end
   end

   // Pending bits: registered timer compare and 2-flop external synchronizer.
   always_comb begin
      mtip_d      = (mtime_q >= mtimecmp_q);
      meip_sync_d = externalIntLine;
      meip_d      = meip_sync_q;
   end

   // Request FSM: latch the winning source in IDLE, hold it through REQ.
   always_comb begin
      state_d     = state_q;
      int_code_d  = int_code_q;
      ext_hit     = meip_q & csrMEIE;
      tmr_hit     = mtip_q & csrMTIE;
      latched_hit = (int_code_q == CODE_EXT) ? ext_hit : tmr_hit;
      case (state_q)
         ST_IDLE: begin
            if (csrMIE & (ext_hit | tmr_hit)) begin
               state_d    = ST_REQ;
               int_code_d = ext_hit ? CODE_EXT : CODE_TMR;
            end
         end
         ST_REQ: begin
            if (intAck) begin
               state_d = ST_IN_HANDLER;
            end else if (!(csrMIE & latched_hit)) begin
               state_d = ST_IDLE;
            end
         end
         ST_IN_HANDLER: begin
            if (mretDone) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State registers.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         presc_q     <= '0;
         mtime_q     <= '0;
         mtimecmp_q  <= '1;
         mtip_q      <= 1'b0;
         meip_sync_q <= 1'b0;
         meip_q      <= 1'b0;
         rdata_q     <= '0;
         rvalid_q    <= 1'b0;
         state_q     <= ST_IDLE;
         int_code_q  <= '0;
      end else begin
         presc_q     <= presc_d;
         mtime_q     <= mtime_d;
         mtimecmp_q  <= mtimecmp_d;
         mtip_q      <= mtip_d;
         meip_sync_q <= meip_sync_d;
         meip_q      <= meip_d;
         rdata_q     <= rdata_d;
         rvalid_q    <= rvalid_d;
         state_q     <= state_d;
         int_code_q  <= int_code_d;
      end
   end

   assign mmioRData  = rdata_q;
   assign mmioRValid = rvalid_q;
   assign mtip       = mtip_q;
   assign meip       = meip_q;
   assign intReq     = (state_q == ST_REQ);
   assign intCode    = int_code_q;

endmodule

// File: tb/tb_interrupt_timer_unit.sv
// Directed bench for interrupt_timer_unit: MMIO table plus timer/IRQ sequences.
module tb_interrupt_timer_unit;

   logic        clk;
   logic        rstN;
   logic        mmioReq;
   logic        mmioWe;
   logic [3:0]  mmioAddr;
   logic [31:0] mmioWData;
   logic        externalIntLine;
   logic        csrMIE, csrMTIE, csrMEIE;
   logic        intAck, mretDone;

   logic [31:0] mmioRData,  rdata4;
   logic        mmioRValid, rvalid4;
   logic        mtip, meip, intReq;
   logic        mtip4, meip4, intReq4;
   logic [4:0]  intCode, intCode4;

   int checks   = 0;
   int failures = 0;

   interrupt_timer_unit #(.PRESCALE(1)) dut (
      .clk(clk), .rstN(rstN), .mmioReq(mmioReq), .mmioWe(mmioWe),
      .mmioAddr(mmioAddr), .mmioWData(mmioWData), .mmioRData(mmioRData),
      .mmioRValid(mmioRValid), .externalIntLine(externalIntLine),
      .csrMIE(csrMIE), .csrMTIE(csrMTIE), .csrMEIE(csrMEIE),
      .mtip(mtip), .meip(meip), .intReq(intReq), .intCode(intCode),
      .intAck(intAck), .mretDone(mretDone)
   );

   interrupt_timer_unit #(.PRESCALE(4)) dut4 (
      .clk(clk), .rstN(rstN), .mmioReq(mmioReq), .mmioWe(mmioWe),
      .mmioAddr(mmioAddr), .mmioWData(mmioWData), .mmioRData(rdata4),
      .mmioRValid(rvalid4), .externalIntLine(externalIntLine),
      .csrMIE(csrMIE), .csrMTIE(csrMTIE), .csrMEIE(csrMEIE),
      .mtip(mtip4), .meip(meip4), .intReq(intReq4), .intCode(intCode4),
      .intAck(intAck), .mretDone(mretDone)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        do_wr;
      logic [3:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mmio_write(input logic [3:0] a, input logic [31:0] d);
      mmioReq = 1'b1; mmioWe = 1'b1; mmioAddr = a; mmioWData = d;
      tick();
      mmioReq = 1'b0; mmioWe = 1'b0;
   endtask

   task automatic mmio_read(input logic [3:0] a, output logic [31:0] d, output logic v);
      mmioReq = 1'b1; mmioWe = 1'b0; mmioAddr = a;
      tick();
      d = mmioRData;
      v = mmioRValid;
      mmioReq = 1'b0;
   endtask

   logic [31:0] rd;
   logic        rv;
   logic [31:0] s4[13];
   logic [31:0] s1[13];
   logic [31:0] diff;

   initial begin
      vecs[0] = '{1'b1, 4'd2, 32'h0000_0010, 32'h0000_0010};
      vecs[1] = '{1'b0, 4'd3, 32'h0,         32'hFFFF_FFFF};
      vecs[2] = '{1'b1, 4'd3, 32'h0000_1234, 32'h0000_1234};
      vecs[3] = '{1'b0, 4'd5, 32'h0,         32'h0};
      vecs[4] = '{1'b1, 4'd6, 32'hDEAD_BEEF, 32'h0};
      vecs[5] = '{1'b0, 4'd2, 32'h0,         32'h0000_0010};
      vecs[6] = '{1'b1, 4'd2, 32'h0000_00AB, 32'h0000_00AB};

      rstN = 1'b0; mmioReq = 1'b0; mmioWe = 1'b0; mmioAddr = '0; mmioWData = '0;
      externalIntLine = 1'b0; csrMIE = 1'b0; csrMTIE = 1'b0; csrMEIE = 1'b0;
      intAck = 1'b0; mretDone = 1'b0;

      #2;
      check("rst_mtip", mtip, 0);
      check("rst_meip", meip, 0);
      check("rst_intReq", intReq, 0);
      check("rst_intCode", intCode, 0);
      check("rst_rdata", mmioRData, 0);
      check("rst_rvalid", mmioRValid, 0);
      tick();
      tick();
      rstN = 1'b1;
      tick();

      // MMIO table: optional write, then read next cycle, valid for one cycle.
      for (int i = 0; i < 7; i++) begin
         if (vecs[i].do_wr) mmio_write(vecs[i].addr, vecs[i].wdata);
         mmio_read(vecs[i].addr, rd, rv);
         check($sformatf("vec%0d_rvalid", i), rv, 1);
         check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
         tick();
         check($sformatf("vec%0d_rvalid_drop", i), mmioRValid, 0);
      end

      // Timer interrupt with mtimecmp = {0, 0x20}, mtime forced to 0x10.
      mmio_write(4'd2, 32'h20);
      mmio_write(4'd3, 32'h0);
      mmio_write(4'd0, 32'h10);
      for (int i = 0; i < 3; i++) tick();
      csrMIE = 1'b1; csrMTIE = 1'b1;
      for (int i = 0; i < 12; i++) tick();
      check("tmr_mtip_pre", mtip, 0);
      tick();
      check("tmr_mtip_T", mtip, 0);
      check("tmr_req_T", intReq, 0);
      tick();
      check("tmr_mtip_T1", mtip, 1);
      check("tmr_req_T1", intReq, 0);
      tick();
      check("tmr_req_T2", intReq, 1);
      check("tmr_code_T2", intCode, 7);
      intAck = 1'b1;
      tick();
      intAck = 1'b0;
      check("tmr_req_after_ack", intReq, 0);
      tick();
      tick();
      check("tmr_req_in_handler", intReq, 0);
      mretDone = 1'b1;
      tick();
      mretDone = 1'b0;
      check("tmr_req_after_mret", intReq, 0);
      tick();
      check("tmr_req_reassert", intReq, 1);
      check("tmr_code_reassert", intCode, 7);

      // Priority: meip rising during a timer request does not re-prioritize.
      externalIntLine = 1'b1; csrMEIE = 1'b1;
      tick();
      check("meip_sync1", meip, 0);
      tick();
      check("meip_sync2", meip, 1);
      tick();
      check("prio_no_reprio_code", intCode, 7);
      check("prio_no_reprio_req", intReq, 1);
      intAck = 1'b1;
      tick();
      intAck = 1'b0; mretDone = 1'b1;
      tick();
      mretDone = 1'b0;
      tick();
      check("prio_ext_req", intReq, 1);
      check("prio_ext_code", intCode, 11);
      csrMEIE = 1'b0; intAck = 1'b1;
      tick();
      intAck = 1'b0;
      check("prio_ack_wins_meie", intReq, 0);
      mretDone = 1'b1;
      tick();
      mretDone = 1'b0;
      tick();
      check("prio_tmr_req", intReq, 1);
      check("prio_tmr_code", intCode, 7);

      // Withdrawal, and ack winning over simultaneous condition loss.
      csrMIE = 1'b0;
      tick();
      check("wd_req_drop", intReq, 0);
      tick();
      check("wd_req_idle", intReq, 0);
      csrMIE = 1'b1;
      tick();
      check("wd_req_again", intReq, 1);
      csrMIE = 1'b0; intAck = 1'b1;
      tick();
      intAck = 1'b0; csrMIE = 1'b1;
      check("wd_ack_wins", intReq, 0);
      tick();
      tick();
      check("wd_in_handler_hold", intReq, 0);
      mretDone = 1'b1;
      tick();
      mretDone = 1'b0;
      check("wd_mret_idle", intReq, 0);
      tick();
      check("wd_req_after_mret", intReq, 1);
      csrMIE = 1'b0; intAck = 1'b1;
      tick();
      intAck = 1'b0; mretDone = 1'b1;
      tick();
      mretDone = 1'b0; externalIntLine = 1'b0;

      // 64-bit wrap.
      mmio_write(4'd1, 32'hFFFF_FFFF);
      mmio_write(4'd0, 32'hFFFF_FFFE);
      tick();
      tick();
      mmio_read(4'd0, rd, rv);
      check("wrap_lo", rd, 0);
      mmio_read(4'd1, rd, rv);
      check("wrap_hi", rd, 0);

      // Write overrides the same-cycle increment.
      mmio_write(4'd0, 32'd5);
      mmio_read(4'd0, rd, rv);
      check("override_lo", rd, 5);

      // Prescale 4 vs 1, back-to-back reads of mtime lo.
      mmioReq = 1'b1; mmioWe = 1'b0; mmioAddr = 4'd0;
      for (int i = 0; i < 13; i++) begin
         tick();
         s4[i] = rdata4;
         s1[i] = mmioRData;
      end
      mmioReq = 1'b0;
      for (int i = 0; i < 9; i++) begin
         diff = s4[i+4] - s4[i];
         check($sformatf("presc4_win%0d", i), diff, 1);
      end
      diff = s4[12] - s4[0];
      check("presc4_total", diff, 3);
      diff = s1[12] - s1[0];
      check("presc1_total", diff, 12);

      // mtip falls one cycle after mtimecmp moves above mtime.
      mmio_write(4'd2, 32'h0);
      tick();
      tick();
      check("fall_mtip_set", mtip, 1);
      mmio_write(4'd3, 32'h1);
      check("fall_mtip_W", mtip, 1);
      tick();
      check("fall_mtip_W1", mtip, 0);

      // Async reset while a request is outstanding.
      mmio_write(4'd3, 32'h0);
      csrMIE = 1'b1; csrMTIE = 1'b1;
      tick();
      tick();
      tick();
      check("arst_req_before", intReq, 1);
      #2;
      rstN = 1'b0;
      #1;
      check("arst_req", intReq, 0);
      check("arst_mtip", mtip, 0);
      check("arst_code", intCode, 0);
      check("arst_rvalid", mmioRValid, 0);
      @(posedge clk);
      #1;
      rstN = 1'b1; csrMIE = 1'b0;
      mmio_read(4'd0, rd, rv);
      check("arst_mtime0", rd, 0);
      mmio_read(4'd0, rd, rv);
      check("arst_mtime1", rd, 1);
      mmio_read(4'd2, rd, rv);
      check("arst_cmp_lo", rd, 32'hFFFF_FFFF);
      mmio_read(4'd3, rd, rv);
      check("arst_cmp_hi", rd, 32'hFFFF_FFFF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
